// File: rtl/floor_request_scheduler.sv
// Elevator call latch and SCAN scheduler. Holds cabin/hall calls, picks the
// travel direction, drives the one-floor-at-a-time move_req/at_floor handshake
// with the motion FSM and times the door dwell at each stop.
// Handshake: move_req stays high for the whole time the FSM is in MOVE; each
// at_floor pulse received in MOVE is one completed floor of travel, evaluated
// against the latched calls in that same cycle. at_floor outside MOVE is ignored.
module floor_request_scheduler #(
   parameter int NUM_FLOORS  = 4,
   parameter int FLOOR_W     = 2,
   parameter int DOOR_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] car_req,
   input  logic [NUM_FLOORS-1:0] hall_up,
   input  logic [NUM_FLOORS-1:0] hall_dn,
   input  logic                  door_hold,
   input  logic                  at_floor,
   input  logic [FLOOR_W-1:0]    cur_floor,
   output logic                  move_req,
   output logic                  move_up,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pend_up,
   output logic [NUM_FLOORS-1:0] pend_dn,
   output logic                  idle,
   output logic [1:0]            dbg_state
);

   localparam int TIMER_W = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DOOR_CYCLES - 1);
   localparam logic [NUM_FLOORS-1:0] ONE_HOT0 = NUM_FLOORS'(1);
   // Top floor has no "up" button, bottom floor has no "down" button.
   localparam logic [NUM_FLOORS-1:0] UP_VALID = {1'b0, {(NUM_FLOORS-1){1'b1}}};
   localparam logic [NUM_FLOORS-1:0] DN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
   localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MOVE  = 2'd1,
      ST_DWELL = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_FLOORS-1:0] car_q, car_d;
   logic [NUM_FLOORS-1:0] up_q, up_d;
   logic [NUM_FLOORS-1:0] dn_q, dn_d;
   logic                  move_up_q, move_up_d;
   logic [TIMER_W-1:0]    timer_q, timer_d;

   logic [NUM_FLOORS-1:0] all_calls;
   logic [NUM_FLOORS-1:0] floor_mask;
   logic                  calls_above, calls_below;
   logic                  ahead, behind;
   logic                  here_any, here_car, here_dir_hall, here_opp_hall;
   logic                  stop_here;
   logic                  new_match;
   logic                  enter_dwell;

   // Where the latched calls sit relative to the car.
   always_comb begin
      all_calls   = car_q | up_q | dn_q;
      floor_mask  = ONE_HOT0 << cur_floor;
      calls_above = 1'b0;
      calls_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i > int'(cur_floor)) calls_above = calls_above | all_calls[i];
         if (i < int'(cur_floor)) calls_below = calls_below | all_calls[i];
      end
      ahead         = move_up_q ? calls_above : calls_below;
      behind        = move_up_q ? calls_below : calls_above;
      here_any      = |(all_calls & floor_mask);
      here_car      = |(car_q & floor_mask);
      here_dir_hall = |((move_up_q ? up_q : dn_q) & floor_mask);
      here_opp_hall = |((move_up_q ? dn_q : up_q) & floor_mask);
      stop_here     = here_car | here_dir_hall | (!ahead && here_opp_hall);
      // A fresh press at the open door that matches the travel direction.
      new_match     = |(car_req & floor_mask) |
                      |((move_up_q ? (hall_up & UP_VALID) : (hall_dn & DN_VALID)) & floor_mask);
   end

   // Next-state, call latching and door timer.
   always_comb begin
      state_d     = state_q;
      car_d       = car_q | car_req;
      up_d        = up_q | (hall_up & UP_VALID);
      dn_d        = dn_q | (hall_dn & DN_VALID);
      move_up_d   = move_up_q;
      timer_d     = timer_q;
      enter_dwell = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (here_any) begin
               enter_dwell = 1'b1;
            end else if (calls_above) begin
               state_d   = ST_MOVE;
               move_up_d = 1'b1;
            end else if (calls_below) begin
               state_d   = ST_MOVE;
               move_up_d = 1'b0;
            end
         end

         ST_MOVE: begin
            if (at_floor) begin
               if (stop_here) begin
                  enter_dwell = 1'b1;
               end else if (all_calls == '0) begin
                  state_d = ST_IDLE;
               end else if (!ahead) begin
                  move_up_d = ~move_up_q;
               end
            end
         end

         ST_DWELL: begin
            if (new_match) begin
               car_d = car_d & ~floor_mask;
               if (move_up_q) up_d = up_d & ~floor_mask;
               else           dn_d = dn_d & ~floor_mask;
            end
            if (door_hold || new_match) begin
               timer_d = TIMER_LOAD;
            end else if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else begin
               if (ahead) begin
                  state_d = ST_MOVE;
               end else if (behind) begin
                  state_d   = ST_MOVE;
                  move_up_d = ~move_up_q;
               end else begin
                  state_d = ST_IDLE;
               end
               if (cur_floor == TOP_FLOOR)     move_up_d = 1'b0;
               else if (cur_floor == '0)       move_up_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Stopping at a floor satisfies the calls there; clears win over same-cycle presses.
      if (enter_dwell) begin
         state_d = ST_DWELL;
         timer_d = TIMER_LOAD;
         car_d   = car_d & ~floor_mask;
         if (move_up_q) up_d = up_d & ~floor_mask;
         else           dn_d = dn_d & ~floor_mask;
         if (!ahead) begin
            up_d      = up_d & ~floor_mask;
            dn_d      = dn_d & ~floor_mask;
            move_up_d = ~move_up_q;
         end
      end
   end

   // State, call and timer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         car_q     <= '0;
         up_q      <= '0;
         dn_q      <= '0;
         move_up_q <= 1'b1;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         car_q     <= car_d;
         up_q      <= up_d;
         dn_q      <= dn_d;
         move_up_q <= move_up_d;
         timer_q   <= timer_d;
      end
   end

   assign move_req  = (state_q == ST_MOVE);
   assign door_open = (state_q == ST_DWELL);
   assign move_up   = move_up_q;
   assign pend_up   = car_q | up_q;
   assign pend_dn   = car_q | dn_q;
   assign idle      = (state_q == ST_IDLE) && (all_calls == '0);
   assign dbg_state = state_q;

endmodule
